// File: rtl/status_cond_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : status_cond_unit_if
// Description : ALU status / condition handshake bundle between the pipeline
//               control (master) and the status_cond_unit flag logic (slave).
// Revision    : 1.0
// ============================================================================
interface status_cond_unit_if;
    logic [3:0] status_in;
    logic       exe_valid;
    logic       s_exe;
    logic       id_valid;
    logic [3:0] cond_id;
    logic       stall;
    logic       flush;
    logic       cond_ok;
    logic       hazard;
    logic       cin;
    logic [3:0] nzcv;
    logic       cond_pass_exe;

    modport master (
        output status_in, exe_valid, s_exe, id_valid, cond_id, stall, flush,
        input  cond_ok, hazard, cin, nzcv, cond_pass_exe
    );

    modport slave (
        input  status_in, exe_valid, s_exe, id_valid, cond_id, stall, flush,
        output cond_ok, hazard, cin, nzcv, cond_pass_exe
    );
endinterface
`default_nettype wire

// File: rtl/status_cond_unit.sv
`default_nettype none
// ============================================================================
// Module      : status_cond_unit
// Description : NZCV flag register, ARM condition evaluation for ID and
//               condition-gated flag commit from EXE.
// Revision    : 1.0
// ============================================================================
module status_cond_unit #(
    parameter bit         BYPASS      = 1'b1,
    parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
    input  wire logic          clk,
    input  wire logic          rst,
    status_cond_unit_if.slave  bus
);

    logic [3:0] r_nzcv;
    logic       r_cond_pass_exe;
    logic       w_flag_we;
    logic [3:0] w_status_nzcv;
    logic [3:0] w_flags;
    logic       w_hazard;
    logic       w_cond_true;
    logic       w_cond_ok;

    assign w_flag_we     = bus.exe_valid & bus.s_exe & r_cond_pass_exe & ~bus.stall;
    // ALU reports {Z,C,N,V}; the architectural register holds {N,Z,C,V}
    assign w_status_nzcv = {bus.status_in[1], bus.status_in[3], bus.status_in[2], bus.status_in[0]};

    generate
        if (BYPASS) begin : g_bypass
            assign w_flags  = w_flag_we ? w_status_nzcv : r_nzcv;
            assign w_hazard = 1'b0;
        end else begin : g_no_bypass
            assign w_flags  = r_nzcv;
            assign w_hazard = bus.id_valid & (bus.cond_id != 4'd14) &
                              bus.exe_valid & bus.s_exe & r_cond_pass_exe;
        end
    endgenerate

    always_comb begin
        w_cond_true = 1'b0;
        case (bus.cond_id)
            4'd0:    w_cond_true = w_flags[2];
            4'd1:    w_cond_true = ~w_flags[2];
            4'd2:    w_cond_true = w_flags[1];
            4'd3:    w_cond_true = ~w_flags[1];
            4'd4:    w_cond_true = w_flags[3];
            4'd5:    w_cond_true = ~w_flags[3];
            4'd6:    w_cond_true = w_flags[0];
            4'd7:    w_cond_true = ~w_flags[0];
            4'd8:    w_cond_true = w_flags[1] & ~w_flags[2];
            4'd9:    w_cond_true = ~w_flags[1] | w_flags[2];
            4'd10:   w_cond_true = (w_flags[3] == w_flags[0]);
            4'd11:   w_cond_true = (w_flags[3] != w_flags[0]);
            4'd12:   w_cond_true = ~w_flags[2] & (w_flags[3] == w_flags[0]);
            4'd13:   w_cond_true = w_flags[2] | (w_flags[3] != w_flags[0]);
            4'd14:   w_cond_true = 1'b1;
            default: w_cond_true = 1'b0;
        endcase
    end

    assign w_cond_ok = bus.id_valid & w_cond_true & ~w_hazard;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_nzcv <= RESET_FLAGS;
        end else if (w_flag_we) begin
            r_nzcv <= w_status_nzcv;
        end
    end

    // A hazard forces cond_ok low, so the EXE slot becomes a bubble
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cond_pass_exe <= 1'b0;
        end else if (!bus.stall) begin
            r_cond_pass_exe <= bus.flush ? 1'b0 : w_cond_ok;
        end
    end

    assign bus.cond_ok       = w_cond_ok;
    assign bus.hazard        = w_hazard;
    assign bus.cin           = r_nzcv[1];
    assign bus.nzcv          = r_nzcv;
    assign bus.cond_pass_exe = r_cond_pass_exe;

endmodule
`default_nettype wire

// File: tb/tb_status_cond_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_status_cond_unit
// Description : Directed self-checking bench; instance b has BYPASS=1,
//               instance n has BYPASS=0, both driven with identical inputs.
// Revision    : 1.0
// ============================================================================
module tb_status_cond_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    status_cond_unit_if bus_b ();
    status_cond_unit_if bus_n ();

    status_cond_unit #(.BYPASS(1'b1), .RESET_FLAGS(4'b0000)) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b.slave));
    status_cond_unit #(.BYPASS(1'b0), .RESET_FLAGS(4'b0000)) dut_n (
        .clk(clk), .rst(rst), .bus(bus_n.slave));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [3:0] st, input logic ev, input logic s,
                          input logic iv, input logic [3:0] cid,
                          input logic stl, input logic fl);
        bus_b.status_in = st; bus_n.status_in = st;
        bus_b.exe_valid = ev; bus_n.exe_valid = ev;
        bus_b.s_exe     = s;  bus_n.s_exe     = s;
        bus_b.id_valid  = iv; bus_n.id_valid  = iv;
        bus_b.cond_id   = cid; bus_n.cond_id  = cid;
        bus_b.stall     = stl; bus_n.stall    = stl;
        bus_b.flush     = fl; bus_n.flush     = fl;
    endtask

    function automatic logic [3:0] alu_order(input logic [3:0] f);
        return {f[2], f[1], f[3], f[0]};
    endfunction

    function automatic logic cond_model(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return cy;
            4'd3:  return !cy;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return cy && !z;
            4'd9:  return !cy || z;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return z || (n != v);
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic load_flags(input logic [3:0] f);
        set_in(4'b0000, 1'b0, 1'b0, 1'b1, 4'd14, 1'b0, 1'b0);
        tick();
        set_in(alu_order(f), 1'b1, 1'b1, 1'b1, 4'd14, 1'b0, 1'b0);
        tick();
        set_in(4'b0000, 1'b0, 1'b0, 1'b1, 4'd14, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        set_in(4'b1111, 1'b1, 1'b1, 1'b1, 4'd14, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        checks++; if (bus_b.nzcv !== 4'b0000) begin errors++; $display("FAIL reset_nzcv got %b exp 0000", bus_b.nzcv); end
        checks++; if (bus_b.cin !== 1'b0) begin errors++; $display("FAIL reset_cin got %b exp 0", bus_b.cin); end
        checks++; if (bus_b.cond_pass_exe !== 1'b0) begin errors++; $display("FAIL reset_cpe got %b exp 0", bus_b.cond_pass_exe); end
        checks++; if (bus_n.nzcv !== 4'b0000) begin errors++; $display("FAIL reset_nzcv_n got %b exp 0000", bus_n.nzcv); end
        @(negedge clk);
        rst = 1'b0;
        set_in(4'b0000, 1'b0, 1'b0, 1'b1, 4'd14, 1'b0, 1'b0);
        #1;
        checks++; if (bus_b.cond_ok !== 1'b1) begin errors++; $display("FAIL reset_al got %b exp 1", bus_b.cond_ok); end
        bus_b.cond_id = 4'd15; bus_n.cond_id = 4'd15;
        #1;
        checks++; if (bus_b.cond_ok !== 1'b0) begin errors++; $display("FAIL reset_nv got %b exp 0", bus_b.cond_ok); end
    endtask

    task automatic test_commit();
        set_in(4'b0000, 1'b0, 1'b0, 1'b1, 4'd14, 1'b0, 1'b0);
        tick();
        checks++; if (bus_b.cond_pass_exe !== 1'b1) begin errors++; $display("FAIL commit_cpe got %b exp 1", bus_b.cond_pass_exe); end
        set_in(4'b1100, 1'b1, 1'b1, 1'b1, 4'd14, 1'b0, 1'b0);
        tick();
        checks++; if (bus_b.nzcv !== 4'b0110) begin errors++; $display("FAIL commit_nzcv got %b exp 0110", bus_b.nzcv); end
        checks++; if (bus_b.cin !== 1'b1) begin errors++; $display("FAIL commit_cin got %b exp 1", bus_b.cin); end
        set_in(4'b0000, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0);
        #1;
        checks++; if (bus_b.cond_ok !== 1'b1) begin errors++; $display("FAIL commit_eq got %b exp 1", bus_b.cond_ok); end
        bus_b.cond_id = 4'd8; bus_n.cond_id = 4'd8;
        #1;
        checks++; if (bus_b.cond_ok !== 1'b0) begin errors++; $display("FAIL commit_hi got %b exp 0", bus_b.cond_ok); end
    endtask

    task automatic test_bypass();
        load_flags(4'b0000);
        set_in(4'b0010, 1'b1, 1'b1, 1'b1, 4'd11, 1'b0, 1'b0);
        #1;
        checks++; if (bus_b.cond_ok !== 1'b1) begin errors++; $display("FAIL bypass_ok got %b exp 1", bus_b.cond_ok); end
        checks++; if (bus_b.hazard !== 1'b0) begin errors++; $display("FAIL bypass_hz got %b exp 0", bus_b.hazard); end
        checks++; if (bus_n.hazard !== 1'b1) begin errors++; $display("FAIL nobyp_hz got %b exp 1", bus_n.hazard); end
        checks++; if (bus_n.cond_ok !== 1'b0) begin errors++; $display("FAIL nobyp_ok got %b exp 0", bus_n.cond_ok); end
        tick();
        checks++; if (bus_b.nzcv !== 4'b1000) begin errors++; $display("FAIL bypass_nzcv got %b exp 1000", bus_b.nzcv); end
        checks++; if (bus_b.cond_pass_exe !== 1'b1) begin errors++; $display("FAIL bypass_cpe got %b exp 1", bus_b.cond_pass_exe); end
        checks++; if (bus_n.nzcv !== 4'b1000) begin errors++; $display("FAIL nobyp_nzcv got %b exp 1000", bus_n.nzcv); end
        checks++; if (bus_n.cond_pass_exe !== 1'b0) begin errors++; $display("FAIL nobyp_bubble got %b exp 0", bus_n.cond_pass_exe); end
        checks++; if (bus_n.hazard !== 1'b0) begin errors++; $display("FAIL nobyp_hz_clr got %b exp 0", bus_n.hazard); end
        checks++; if (bus_n.cond_ok !== 1'b1) begin errors++; $display("FAIL nobyp_ok_after got %b exp 1", bus_n.cond_ok); end
    endtask

    task automatic test_gated();
        set_in(4'b0000, 1'b0, 1'b0, 1'b0, 4'd14, 1'b0, 1'b0);
        tick();
        checks++; if (bus_b.cond_pass_exe !== 1'b0) begin errors++; $display("FAIL gated_cpe got %b exp 0", bus_b.cond_pass_exe); end
        set_in(4'b1111, 1'b1, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0);
        #1;
        checks++; if (bus_b.cond_ok !== 1'b0) begin errors++; $display("FAIL gated_nobypass got %b exp 0", bus_b.cond_ok); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (bus_b.nzcv !== 4'b1000) begin errors++; $display("FAIL gated_nzcv cyc %0d got %b exp 1000", i, bus_b.nzcv); end
        end
    endtask

    task automatic test_stall_flush();
        set_in(4'b0000, 1'b0, 1'b0, 1'b1, 4'd14, 1'b0, 1'b0);
        tick();
        set_in(4'b0100, 1'b1, 1'b1, 1'b1, 4'd3, 1'b1, 1'b1);
        #1;
        checks++; if (bus_b.cond_ok !== 1'b1) begin errors++; $display("FAIL stall_nobypass got %b exp 1", bus_b.cond_ok); end
        checks++; if (bus_n.hazard !== 1'b1) begin errors++; $display("FAIL stall_hz got %b exp 1", bus_n.hazard); end
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (bus_b.nzcv !== 4'b1000) begin errors++; $display("FAIL stall_nzcv got %b exp 1000", bus_b.nzcv); end
            checks++; if (bus_b.cond_pass_exe !== 1'b1) begin errors++; $display("FAIL stall_cpe got %b exp 1", bus_b.cond_pass_exe); end
        end
        set_in(4'b0100, 1'b1, 1'b1, 1'b1, 4'd14, 1'b0, 1'b1);
        tick();
        checks++; if (bus_b.nzcv !== 4'b0010) begin errors++; $display("FAIL flush_nzcv got %b exp 0010", bus_b.nzcv); end
        checks++; if (bus_b.cin !== 1'b1) begin errors++; $display("FAIL flush_cin got %b exp 1", bus_b.cin); end
        checks++; if (bus_b.cond_pass_exe !== 1'b0) begin errors++; $display("FAIL flush_cpe got %b exp 0", bus_b.cond_pass_exe); end
        checks++; if (bus_n.nzcv !== 4'b0010) begin errors++; $display("FAIL flush_nzcv_n got %b exp 0010", bus_n.nzcv); end
    endtask

    task automatic test_decode();
        logic [3:0] f;
        logic [3:0] c;
        logic       exp;
        for (int fi = 0; fi < 16; fi++) begin
            f = fi[3:0];
            load_flags(f);
            checks++; if (bus_b.nzcv !== f) begin errors++; $display("FAIL dec_load got %b exp %b", bus_b.nzcv, f); end
            if (fi == 8) begin
                @(negedge clk);
                #2 rst = 1'b1;
                #1;
                checks++; if (bus_b.nzcv !== 4'b0000) begin errors++; $display("FAIL async_nzcv got %b exp 0000", bus_b.nzcv); end
                checks++; if (bus_b.cond_pass_exe !== 1'b0) begin errors++; $display("FAIL async_cpe got %b exp 0", bus_b.cond_pass_exe); end
                checks++; if (bus_b.cin !== 1'b0) begin errors++; $display("FAIL async_cin got %b exp 0", bus_b.cin); end
                @(negedge clk);
                rst = 1'b0;
                load_flags(f);
            end
            for (int ci = 0; ci < 16; ci++) begin
                c = ci[3:0];
                bus_b.cond_id = c; bus_n.cond_id = c;
                #1;
                exp = cond_model(c, f);
                checks++; if (bus_b.cond_ok !== exp) begin errors++; $display("FAIL dec_b f=%b c=%0d got %b exp %b", f, c, bus_b.cond_ok, exp); end
                checks++; if (bus_n.cond_ok !== exp) begin errors++; $display("FAIL dec_n f=%b c=%0d got %b exp %b", f, c, bus_n.cond_ok, exp); end
            end
        end
    endtask

    initial begin
        set_in(4'b0000, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        test_reset();
        test_commit();
        test_bypass();
        test_gated();
        test_stall_flush();
        test_decode();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/status_cond_unit.md
Name: status_cond_unit

Overview:
- Consumer side of the ALU status interface.
- Holds the architectural NZCV flag register.
- Commits ALU status bits from the EXE stage, with flag writes gated by the EXE instruction's own condition result.
- Evaluates the 4-bit ARM condition field of the instruction in ID and supplies the carry-in (cin) for ADC/SBC in EXE.

Parameters:
BYPASS, 1, 1: ID condition evaluation uses flags being committed this cycle; 0: raise hazard instead
RESET_FLAGS, 4'b0000, reset value of the flag register, in {N,Z,C,V} order

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous active-high reset
status_in  input  4  ALU status, order {Z,C,N,V} (bit3=Z, bit2=C, bit1=N, bit0=V)
exe_valid  input  1  EXE stage holds a real instruction
s_exe  input  1  S bit of the EXE instruction (update flags)
id_valid  input  1  ID stage holds a real instruction
cond_id  input  4  condition field of the ID instruction
stall  input  1  pipeline freeze; no state changes
flush  input  1  kill the ID->EXE transfer (branch taken)
cond_ok  output  1  ID instruction condition passes (combinational)
hazard  output  1  flag hazard, ID must stall (BYPASS=0 only)
cin  output  1  registered C flag, to ALU cin
nzcv  output  4  flag register, order {N,Z,C,V}
cond_pass_exe  output  1  registered condition result of the EXE instruction

Behaviour:
- Reset (async, immediate):
  - nzcv=RESET_FLAGS, cin=RESET_FLAGS[1].
  - cond_pass_exe=0.
  - Combinational outputs follow from the reset state.
- Flag register:
  - Define flag_we = exe_valid & s_exe & cond_pass_exe & ~stall.
  - On a clock edge with flag_we, nzcv <= {status_in[1], status_in[3], status_in[2], status_in[0]}, i.e. the ALU order {Z,C,N,V} is reordered to {N,Z,C,V}.
  - Otherwise nzcv holds.
  - All four flags are written together; there are no partial writes.
- cin = nzcv[1] (registered C). It never takes the same-cycle ALU value.
- Condition decode on flag set F. F is chosen as follows:
  - BYPASS=1 and flag_we: F = the reordered status_in.
  - Otherwise: F = nzcv.
- Condition codes:
  - 0 EQ: Z
  - 1 NE: !Z
  - 2 CS: C
  - 3 CC: !C
  - 4 MI: N
  - 5 PL: !N
  - 6 VS: V
  - 7 VC: !V
  - 8 HI: C&!Z
  - 9 LS: !C|Z
  - 10 GE: N==V
  - 11 LT: N!=V
  - 12 GT: !Z&(N==V)
  - 13 LE: Z|(N!=V)
  - 14 AL: 1
  - 15 NV: 0
- cond_ok = id_valid & decode(cond_id, F) & ~hazard.
- Hazard:
  - BYPASS=0: hazard = id_valid & (cond_id!=14) & exe_valid & s_exe & cond_pass_exe.
  - BYPASS=1: hazard=0.
  - hazard ignores stall. The upstream stage must hold ID while hazard=1.
- cond_pass_exe update, in priority order:
  1. stall: hold.
  2. flush: load 0.
  3. otherwise: load cond_ok.
  - A hazard cycle therefore loads 0, i.e. a bubble is inserted.
- Simultaneous events:
  - stall overrides flush and flag_we; nothing changes.
  - flush does not block the flag write of the instruction currently in EXE.
- A failed-condition EXE instruction with s_exe=1 never writes flags.
- rst asserted mid-cycle overrides everything, asynchronously.

Test Plan:
1. Reset:
   - Stimulus: assert rst with any inputs.
   - Response: nzcv=0000, cin=0, cond_pass_exe=0.
   - Then cond_id=14, id_valid=1 -> cond_ok=1; cond_id=15 -> cond_ok=0.
2. Flag commit:
   - Stimulus: cond_pass_exe=1, exe_valid=1, s_exe=1, status_in=4'b1100 (Z=1, C=1).
   - Response: next cycle nzcv=0110, cin=1.
   - cond_id=0 -> cond_ok=1; cond_id=8 -> cond_ok=0.
3. Bypass (BYPASS=1):
   - Stimulus: nzcv=0000; the same cycle commits status_in=0010 (N=1); cond_id=11 (LT).
   - Response: cond_ok=1 that cycle; hazard=0.
   - With BYPASS=0 and the same stimulus: hazard=1, cond_ok=0, and cond_pass_exe loads 0.
4. Gated write:
   - Stimulus: cond_pass_exe=0, exe_valid=1, s_exe=1, status_in=1111.
   - Response: nzcv unchanged for all cycles.
5. Stall/flush priority:
   - Stimulus: stall=1 and flush=1 with a flag write pending.
   - Response: nzcv and cond_pass_exe hold.
   - Then stall=0, flush=1: cond_pass_exe=0 and the pending flag write still commits.
6. Exhaustive decode:
   - Stimulus: sweep all 16 nzcv values × 16 cond_id values with no flag write.
   - Response: cond_ok matches the condition-code list above for all 256 combinations.
   - Async reset asserted mid-sweep clears the state immediately, without waiting for a clock edge.
